// File: rtl/sys_arr_host.sv
// sys_arr_host: operand/result stream host for the systolic array.
// Streams A then B out, captures C, and times start-to-done.
module sys_arr_host #(
    parameter int M  = 8,
    parameter int N  = 2,
    parameter int K  = 8,
    parameter int BW = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_en,
    input  logic [$clog2(M*N+K*N)-1:0] load_addr,
    input  logic [31:0]                load_dat,
    input  logic                       start,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [BW*32-1:0]           out_stream,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [BW*32-1:0]           in_stream,
    input  logic [$clog2(M*K)-1:0]     rd_addr,
    output logic [31:0]                rd_dat,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [31:0]                cycle_cnt
);
    localparam int OPW = M*N + K*N;
    localparam int RSW = M*K;
    localparam int TXB = OPW / BW;
    localparam int RXB = RSW / BW;
    localparam int AW  = $clog2(OPW);
    localparam int RAW = $clog2(RSW);
    localparam int TBW = $clog2(TXB + 1);
    localparam int RBW = $clog2(RXB + 1);
    localparam logic [TBW-1:0] TX_LAST = TBW'(TXB - 1);
    localparam logic [RBW-1:0] RX_LAST = RBW'(RXB - 1);
    localparam logic [RBW-1:0] RX_END  = RBW'(RXB);

    typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [31:0]    op_mem  [OPW];
    logic [31:0]    res_mem [RSW];
    logic [TBW-1:0] tx_beat;
    logic [RBW-1:0] rx_beat;
    logic           tx_hs;
    logic           rx_hs;
    logic           rx_all;
    logic           idle_like;
    logic           go;

    assign tx_hs     = out_valid && out_ready;
    assign rx_hs     = in_valid && in_ready;
    assign idle_like = (state == IDLE) || (state == DONE);
    assign go        = start && idle_like;
    // Results may complete before or together with the last send beat.
    assign rx_all    = (rx_beat == RX_END) || (rx_hs && (rx_beat == RX_LAST));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state: finish only once both directions are complete.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = SEND;
            SEND: if (tx_hs && (tx_beat == TX_LAST))
                      state_nxt = rx_all ? DONE : RECV;
            RECV: if (rx_all) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state; operand beat muxed from operand RAM.
    always_comb begin
        out_valid = (state == SEND);
        busy      = (state == SEND) || (state == RECV);
        done      = (state == DONE);
        in_ready  = busy && (rx_beat != RX_END);
        for (int w = 0; w < BW; w++)
            out_stream[w*32 +: 32] = op_mem[AW'(int'(tx_beat) * BW + w)];
    end

    // Beat counters, saturating cycle counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_beat   <= '0;
            rx_beat   <= '0;
            cycle_cnt <= '0;
            err       <= 1'b0;
        end else begin
            if (go) begin
                tx_beat   <= '0;
                rx_beat   <= '0;
                cycle_cnt <= '0;
            end else begin
                if (tx_hs && (tx_beat != TX_LAST))
                    tx_beat <= tx_beat + TBW'(1);
                if (rx_hs)
                    rx_beat <= rx_beat + RBW'(1);
                if (busy && (cycle_cnt != '1))
                    cycle_cnt <= cycle_cnt + 32'd1;
            end
            if ((start && busy) || (in_valid && idle_like))
                err <= 1'b1;
        end
    end

    // Operand RAM write port, open only while no transfer runs.
    always_ff @(posedge clk) begin
        if (load_en && idle_like)
            op_mem[load_addr] <= load_dat;
    end

    // Result RAM write port: one full beat per accepted handshake.
    always_ff @(posedge clk) begin
        if (rx_hs)
            for (int w = 0; w < BW; w++)
                res_mem[RAW'(int'(rx_beat) * BW + w)] <= in_stream[w*32 +: 32];
    end

    // Registered result RAM read port.
    always_ff @(posedge clk) begin
        if (rst) rd_dat <= '0;
        else     rd_dat <= res_mem[rd_addr];
    end
endmodule

// File: tb/tb_sys_arr_host.sv
// tb_sys_arr_host: scoreboard bench for sys_arr_host (M=N=K=2, BW=2).
// Expected beats/results come from a word-array model of the host.
module tb_sys_arr_host;
    localparam int M   = 2;
    localparam int N   = 2;
    localparam int K   = 2;
    localparam int BW  = 2;
    localparam int OPW = M*N + K*N;
    localparam int RSW = M*K;
    localparam int TXB = OPW / BW;
    localparam int RXB = RSW / BW;
    localparam int AW  = $clog2(OPW);
    localparam int RAW = $clog2(RSW);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             load_en = 1'b0;
    logic [AW-1:0]    load_addr = '0;
    logic [31:0]      load_dat = '0;
    logic             start = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [BW*32-1:0] out_stream;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [BW*32-1:0] in_stream = '0;
    logic [RAW-1:0]   rd_addr = '0;
    logic [31:0]      rd_dat;
    logic             busy;
    logic             done;
    logic             err;
    logic [31:0]      cycle_cnt;

    sys_arr_host #(.M(M), .N(N), .K(K), .BW(BW)) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
        .load_dat(load_dat), .start(start), .out_valid(out_valid),
        .out_ready(out_ready), .out_stream(out_stream), .in_valid(in_valid),
        .in_ready(in_ready), .in_stream(in_stream), .rd_addr(rd_addr),
        .rd_dat(rd_dat), .busy(busy), .done(done), .err(err),
        .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int tx_cnt = 0;
    int last_tx = 0;
    int last_rx = 0;
    int cnt_exp = 0;
    int rx_idx = 0;
    int rmode = 0;
    logic rd_en = 1'b0;
    logic rd_en_d = 1'b0;

    logic [31:0]      op_model  [OPW];
    logic [31:0]      res_model [RSW];
    logic [BW*32-1:0] exp_beats [$];
    logic [31:0]      exp_rd    [$];
    int               exp_start [$];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rd_en_d <= rd_en;

    // Output ready pattern generator.
    int pat = 0;
    initial forever begin
        @(posedge clk); #1;
        case (rmode)
            0: out_ready = 1'b1;
            1: out_ready = (pat % 3 == 0);
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
        pat++;
    end

    // Monitor: pops expectations whenever the DUT presents something.
    logic             prev_stall = 1'b0;
    logic             expect_low = 1'b0;
    logic             done_q = 1'b0;
    logic [BW*32-1:0] prev_stream = '0;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
            expect_low = 1'b0;
            done_q = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_data", out_stream, prev_stream);
            end
            if (expect_low) chk("valid_drop", 64'(out_valid), 64'd0);
            expect_low = 1'b0;
            if (out_valid && out_ready) begin
                if (exp_beats.size() == 0) chk("extra_beat", 64'd1, 64'd0);
                else chk("beat", out_stream, exp_beats.pop_front());
                tx_cnt++;
                last_tx = cyc + 1;
                if (exp_beats.size() == 0) expect_low = 1'b1;
            end
            prev_stall = out_valid && !out_ready;
            prev_stream = out_stream;
            if (in_valid && in_ready) last_rx = cyc + 1;
            if (done && !done_q) begin
                if (exp_start.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    cnt_exp = cyc - exp_start.pop_front();
                    chk("cycle_cnt", 64'(cycle_cnt), 64'(cnt_exp));
                    chk("done_time", 64'(cyc),
                        64'((last_tx > last_rx) ? last_tx : last_rx));
                end
            end
            done_q = done;
            if (rd_en_d) begin
                if (exp_rd.size() == 0) chk("extra_rd", 64'd1, 64'd0);
                else chk("rd_dat", 64'(rd_dat), 64'(exp_rd.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_beats.delete();
        exp_start.delete();
        tick();
        rst = 1'b0;
    endtask

    task automatic load_word(input int a, input logic [31:0] d);
        load_en = 1'b1;
        load_addr = AW'(a);
        load_dat = d;
        op_model[a] = d;
        tick();
        load_en = 1'b0;
    endtask

    task automatic load_random();
        for (int i = 0; i < OPW; i++) load_word(i, $urandom);
    endtask

    task automatic do_start();
        logic [BW*32-1:0] b;
        for (int i = 0; i < TXB; i++) begin
            for (int w = 0; w < BW; w++) b[w*32 +: 32] = op_model[i*BW + w];
            exp_beats.push_back(b);
        end
        exp_start.push_back(cyc + 1);
        tx_cnt = 0;
        rx_idx = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input logic [BW*32-1:0] beat, input int gap);
        repeat (gap) tick();
        in_valid = 1'b1;
        in_stream = beat;
        for (int t = 0; ; t++) begin
            @(negedge clk);
            if (in_ready) break;
            if (t > 200) begin
                chk("feed_timeout", 64'd0, 64'd1);
                break;
            end
        end
        tick();
        in_valid = 1'b0;
        for (int w = 0; w < BW; w++)
            res_model[rx_idx*BW + w] = beat[w*32 +: 32];
        rx_idx++;
    endtask

    task automatic feed_random(input int maxgap);
        logic [BW*32-1:0] b;
        for (int i = 0; i < RXB; i++) begin
            for (int w = 0; w < BW; w++) b[w*32 +: 32] = $urandom;
            feed(b, $urandom_range(0, maxgap));
        end
    endtask

    task automatic wait_done();
        for (int t = 0; ; t++) begin
            @(negedge clk);
            if (done) break;
            if (t > 400) begin
                chk("done_timeout", 64'd0, 64'd1);
                break;
            end
        end
        tick();
        chk("tx_count", 64'(tx_cnt), 64'(TXB));
    endtask

    task automatic read_all();
        for (int a = 0; a < RSW; a++) begin
            rd_en = 1'b1;
            rd_addr = RAW'(a);
            exp_rd.push_back(res_model[a]);
            tick();
        end
        rd_en = 1'b0;
        tick();
        tick();
    endtask

    logic [31:0] fl [8] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                            32'h40800000, 32'h40A00000, 32'h40C00000,
                            32'h40E00000, 32'h41000000};

    initial begin
        do_reset();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_cycle_cnt", 64'(cycle_cnt), 64'd0);
        chk("rst_rd_dat", 64'(rd_dat), 64'd0);

        // Known operands, full-rate send, early results.
        rmode = 0;
        for (int i = 0; i < OPW; i++) load_word(i, fl[i]);
        tick();
        do_start();
        chk("start_valid", 64'(out_valid), 64'd1);
        chk("start_busy", 64'(busy), 64'd1);
        feed({32'h41980000, 32'h41300000}, 0);
        feed({32'h42860000, 32'h42300000}, 0);
        wait_done();
        chk("send_span", 64'(last_tx - (cyc - 1 - cnt_exp)), 64'(TXB));
        read_all();
        chk("done_hold", 64'(done), 64'd1);
        chk("cnt_frozen", 64'(cycle_cnt), 64'(cnt_exp));

        // Stalled output 1,0,0 pattern with gapped results.
        rmode = 1;
        load_random();
        do_start();
        feed_random(3);
        wait_done();
        read_all();

        // Start during RECV flags err without disturbing the transfer.
        rmode = 0;
        load_random();
        do_start();
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (busy && !out_valid) break;
        end
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("err_start_busy", 64'(err), 64'd1);
        chk("still_busy", 64'(busy), 64'd1);
        feed_random(2);
        wait_done();
        read_all();
        chk("err_sticky", 64'(err), 64'd1);

        // in_valid in IDLE: err set, beat dropped, RAM kept over reset.
        do_reset();
        chk("err_cleared", 64'(err), 64'd0);
        in_valid = 1'b1;
        in_stream = {$urandom, $urandom};
        tick();
        in_valid = 1'b0;
        chk("err_in_idle", 64'(err), 64'd1);
        chk("idle_in_ready", 64'(in_ready), 64'd0);
        read_all();

        // Reset after two send beats, then a clean resend.
        do_reset();
        load_random();
        do_start();
        tick();
        tick();
        do_reset();
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_cnt", 64'(cycle_cnt), 64'd0);
        rmode = 2;
        do_start();
        feed_random(4);
        wait_done();
        read_all();

        // Random back-to-back transfers restarted from DONE.
        for (int r = 0; r < 6; r++) begin
            rmode = $urandom_range(0, 2);
            load_random();
            do_start();
            feed_random($urandom_range(0, 5));
            wait_done();
            read_all();
        end
        chk("err_clean", 64'(err), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule

// File: doc/sys_arr_host.md
# sys_arr_host

Stream host for the systolic array: holds operand matrices A (MxN) and B (NxK) in a local operand RAM, transmits them as an AXI-stream master into the array's input stream, then acts as AXI-stream slave to capture the MxK result C into a local result RAM. Sits on the far end of both array stream ports in the test harness and FPGA top level, and measures start-to-done cycle count for throughput characterisation.

## Interface
- M, 8, rows of A / rows of C
- N, 2, columns of A / rows of B
- K, 8, columns of B / columns of C
- BW, 16, 32-bit words per stream beat; (M*N+K*N) and M*K must be multiples of BW
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- load_en  in  1  write one operand word into operand RAM
- load_addr  in  $clog2(M*N+K*N)  operand word index (A row-major at 0..M*N-1, then B column-major)
- load_dat  in  32  operand word (IEEE-754 single)
- start  in  1  single-cycle pulse, begins a transfer
- out_valid  out  1  operand beat valid (master side)
- out_ready  in  1  array input ready
- out_stream  out  BW*32  operand beat; word 0 in bits [31:0]
- in_valid  in  1  result beat valid (slave side)
- in_ready  out  1  host ready for result beat
- in_stream  in  BW*32  result beat; word 0 = C[0][0], row-major
- rd_addr  in  $clog2(M*K)  result RAM read index
- rd_dat  out  32  result word, one-cycle read latency
- busy  out  1  transfer in progress
- done  out  1  all result words captured
- err  out  1  sticky: result beat offered outside RECV window, or start while busy
- cycle_cnt  out  32  cycles from start to done

## Operation
- States: IDLE, SEND, RECV, DONE.
- IDLE: out_valid=0, in_ready=0. load_en writes operand RAM. start -> SEND; clears done, cycle_cnt, beat counters.
- SEND: out_stream = operand words [tx_beat*BW .. tx_beat*BW+BW-1]; out_valid=1. Handshake (out_valid&out_ready) advances tx_beat. After beat (M*N+K*N)/BW-1 handshakes -> RECV. in_ready=1 during SEND as well (results may arrive early); early beats stored normally.
- RECV: in_ready=1 until rx_beat reaches M*K/BW. Each in_valid&in_ready writes BW words to result RAM at rx_beat*BW and increments rx_beat. When all result beats received and SEND complete -> DONE.
- DONE: done=1, busy=0, in_ready=0; held until next start (-> SEND) or rst.
- load_en ignored when not IDLE/DONE. start while SEND/RECV ignored, sets err.
- in_valid in IDLE/DONE sets err; beat not stored.
- cycle_cnt increments every cycle in SEND/RECV; saturates at 2^32-1; frozen in DONE.
- rd_dat readable in any state; operand and result RAM not cleared by rst.

## Timing
- Reset values: out_valid=0, in_ready=0, busy=0, done=0, err=0, cycle_cnt=0, rd_dat=0, state IDLE.
- start at edge t -> out_valid=1 and busy=1 from t+1.
- out_stream and out_valid stable while out_valid=1 and out_ready=0; never withdrawn without handshake.
- out_ready held 1 -> one beat per cycle, no bubbles; last send handshake at cycle t+(M*N+K*N)/BW.
- out_valid drops the cycle after the last send handshake.
- done rises the cycle after the final result handshake (or after last send handshake, whichever later).
- rd_addr at edge t -> rd_dat valid after edge t+1.
- rst mid-transfer: next cycle all outputs at reset values, counters cleared, state IDLE.

## Test plan
- M=N=K=2, BW=2: load words 1.0..8.0, start, out_ready=1 -> beats {2.0,1.0},{4.0,3.0},{6.0,5.0},{8.0,7.0} (high:low) on 4 consecutive cycles, out_valid low on 5th.
- Same config, out_ready toggled 1,0,0,1,... -> out_stream held constant on stalled cycles, exactly 4 handshakes total.
- Feed result beats {0x41980000,0x41300000},{0x42860000,0x42300000} -> rd_addr 0..3 returns 0x41300000,0x41980000,0x42300000,0x42860000; done=1 one cycle after second beat.
- in_valid with in_ready stall pattern and results arriving during SEND -> all 4 words stored in order, done only after both send and receive complete, cycle_cnt equals elapsed cycles.
- rst asserted mid-SEND (after 2 beats) -> out_valid=0, busy=0 next cycle; new start resends from beat 0.
- start pulse during RECV and in_valid in IDLE -> err=1 and sticky, transfer unaffected.
